// File: rtl/audio_avg_filter.sv
// ---------------------------------------------------------------------------
// audio_avg_filter
//
// Sits between the audio codec ADC (read) and DAC (write) ports. For every
// stereo sample it pops one pair from the codec, runs a per-channel N-tap
// moving average (N = 2**TAPS_LOG2) and pushes the filtered pair back. A
// 5-state FSM owns the codec read/write strobes, so exactly one read is
// issued per write.
//
// Optional feature (compile-time macro AVG_BYPASS_EN):
//   When defined, an extra input 'bypass' selects the raw latched sample as
//   the output instead of the average. The filter history keeps updating so
//   the average is coherent as soon as bypass drops.
//
// Ports:
//   CLOCK_50        in   system clock, all logic on the rising edge
//   resetn          in   synchronous reset, active-low
//   read_ready      in   codec has an ADC sample pair available
//   write_ready     in   codec can accept a DAC sample pair
//   bypass          in   (AVG_BYPASS_EN only) pass raw samples through
//   readdata_left   in   codec left ADC sample  (signed, DATA_W)
//   readdata_right  in   codec right ADC sample (signed, DATA_W)
//   read            out  one-cycle pop strobe to codec (registered)
//   write           out  one-cycle push strobe to codec (registered)
//   writedata_left  out  filtered left sample, registered
//   writedata_right out  filtered right sample, registered
// ---------------------------------------------------------------------------
module audio_avg_filter #(
  parameter int DATA_W    = 24,
  parameter int TAPS_LOG2 = 3
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              read_ready,
  input  logic              write_ready,
`ifdef AVG_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right
);

  localparam int N     = 1 << TAPS_LOG2;
  // Wide enough to hold the sum of N full-scale samples without overflow.
  localparam int ACC_W = DATA_W + TAPS_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_WAIT_WR,
    S_WRITE
  } state_e;

  state_e                 state_q;
  logic                   read_q;
  logic                   write_q;
  logic [DATA_W-1:0]      sample_l_q;
  logic [DATA_W-1:0]      sample_r_q;
  logic [DATA_W-1:0]      buf_l_q [N];
  logic [DATA_W-1:0]      buf_r_q [N];
  logic [TAPS_LOG2-1:0]   ptr_q;
  logic [ACC_W-1:0]       acc_l_q;
  logic [ACC_W-1:0]       acc_r_q;
  logic [DATA_W-1:0]      wd_l_q;
  logic [DATA_W-1:0]      wd_r_q;

  logic [ACC_W-1:0]       acc_l_d;
  logic [ACC_W-1:0]       acc_r_d;
  logic [DATA_W-1:0]      out_l_d;
  logic [DATA_W-1:0]      out_r_d;

  function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] x);
    return {{TAPS_LOG2{x[DATA_W-1]}}, x};
  endfunction

  // Running sum: add the newest sample, drop the one it overwrites.
  // Two's complement wrap-around in the add/subtract is harmless because
  // the true result always fits in ACC_W bits.
  assign acc_l_d = acc_l_q + sext(sample_l_q) - sext(buf_l_q[ptr_q]);
  assign acc_r_d = acc_r_q + sext(sample_r_q) - sext(buf_r_q[ptr_q]);

  // Dropping the low TAPS_LOG2 bits is an arithmetic shift right, i.e. a
  // divide by N rounding toward -inf, and leaves exactly DATA_W bits.
`ifdef AVG_BYPASS_EN
  assign out_l_d = bypass ? sample_l_q : acc_l_d[ACC_W-1:TAPS_LOG2];
  assign out_r_d = bypass ? sample_r_q : acc_r_d[ACC_W-1:TAPS_LOG2];
`else
  assign out_l_d = acc_l_d[ACC_W-1:TAPS_LOG2];
  assign out_r_d = acc_r_d[ACC_W-1:TAPS_LOG2];
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      ptr_q      <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      wd_l_q     <= '0;
      wd_r_q     <= '0;
      // NOTE: the delay lines are cleared on reset because the running sum
      // restarts at zero; stale taps would otherwise be subtracted later and
      // leave a permanent offset. This keeps them in flops, not a RAM.
      for (int i = 0; i < N; i++) begin
        buf_l_q[i] <= '0;
        buf_r_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (read_ready) begin
            state_q <= S_READ;
            read_q  <= 1'b1;
          end
        end
        S_READ: begin
          // Data is latched even if read_ready has already dropped.
          sample_l_q <= readdata_left;
          sample_r_q <= readdata_right;
          read_q     <= 1'b0;
          state_q    <= S_CALC;
        end
        S_CALC: begin
          acc_l_q        <= acc_l_d;
          acc_r_q        <= acc_r_d;
          buf_l_q[ptr_q] <= sample_l_q;
          buf_r_q[ptr_q] <= sample_r_q;
          ptr_q          <= ptr_q + TAPS_LOG2'(1);
          wd_l_q         <= out_l_d;
          wd_r_q         <= out_r_d;
          state_q        <= S_WAIT_WR;
        end
        S_WAIT_WR: begin
          if (write_ready) begin
            state_q <= S_WRITE;
            write_q <= 1'b1;
          end
        end
        S_WRITE: begin
          write_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign read            = read_q;
  assign write           = write_q;
  assign writedata_left  = wd_l_q;
  assign writedata_right = wd_r_q;

endmodule
